llr_iq_noise_packer: RTL and testbench

//  Upstream stage of the slow-PHY-to-LLR path. Takes per-RE equalised I/Q samples and per-group noise

---
 rtl/llr_pkg.sv | 28 ++
 rtl/llr_lane_packer.sv | 76 +++++++
 rtl/llr_iq_noise_packer.sv | 155 +++++++++++++++
 tb/tb_llr_iq_noise_packer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/llr_pkg.sv
// rtl/llr_pkg.sv - shared constants and FSM encoding for the slow-PHY IQ/noise packer
//
// Purpose : default sample/word widths, FIFO word bit-field offsets and the
//           one-hot state encoding used by llr_iq_noise_packer.
// Ports   : none (package).
package llr_pkg;

    localparam int LLR_DATA_W      = 16;
    localparam int LLR_RE_PER_WORD = 4;
    localparam int LLR_NZ_PER_WORD = 8;
    localparam int LLR_CNT_W       = 16;

    // IQ word: RE k occupies [IQ_RE_STRIDE*k +: IQ_RE_STRIDE], I in the low half.
    localparam int LLR_IQ_I_OFS     = 0;
    localparam int LLR_IQ_Q_OFS     = LLR_DATA_W;
    localparam int LLR_IQ_RE_STRIDE = 2 * LLR_DATA_W;
    // Noise word: sample k occupies [NZ_STRIDE*k +: NZ_STRIDE].
    localparam int LLR_NZ_STRIDE    = LLR_DATA_W;
    localparam int LLR_WORD_W       = LLR_RE_PER_WORD * LLR_IQ_RE_STRIDE;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_PACK  = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } llr_state_e;

endpackage

// File: rtl/llr_lane_packer.sv
// rtl/llr_lane_packer.sv - packs LANES samples of LANE_W bits into one FIFO word
//
// Purpose : slot index + assembly register + one-deep pending register for a
//           single stream. A word completes on the last slot or on in_last;
//           unfilled slots stay zero. The pending word is offered to the FIFO
//           combinationally and may be reloaded in the cycle it drains.
// Ports   : clk, rstn (async, active-low)
//           allow            - upstream permission to accept (FSM/count gating)
//           in_valid/in_ready, in_data, in_last - sample handshake
//           fifo_full, wr_en, wdata           - FIFO write side
//           pend_valid       - pending word not yet written
import llr_pkg::*;

module llr_lane_packer #(
    parameter int LANE_W = 32,
    parameter int LANES  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     allow,
    input  logic                     in_valid,
    input  logic [LANE_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic                     fifo_full,
    output logic                     wr_en,
    output logic [LANE_W*LANES-1:0]  wdata,
    output logic                     pend_valid
);

    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WORD_W = LANE_W * LANES;

    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] asm_word;
    logic [WORD_W-1:0] pend_word;
    logic [WORD_W-1:0] word_next;
    logic              fire;
    logic              complete;

    // A full FIFO only matters if a pending word is still waiting for it.
    assign in_ready = allow & (~pend_valid | ~fifo_full);
    assign fire     = in_ready & in_valid;
    assign complete = fire & ((idx == IDX_W'(LANES - 1)) | in_last);
    assign wr_en    = pend_valid & ~fifo_full;
    assign wdata    = pend_word;

    always_comb begin
        word_next = asm_word;
        word_next[idx*LANE_W +: LANE_W] = in_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx        <= '0;
            asm_word   <= '0;
            pend_word  <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                pend_valid <= 1'b0;
            end
            // Completion after the drain so a same-cycle reload keeps pend_valid set.
            if (complete) begin
                pend_word  <= word_next;
                pend_valid <= 1'b1;
                asm_word   <= '0;
                idx        <= '0;
            end else if (fire) begin
                asm_word <= word_next;
                idx      <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/llr_iq_noise_packer.sv
// rtl/llr_iq_noise_packer.sv - per-user IQ/noise packer feeding the LLR sender FIFOs
//
// Purpose : one user at a time: start pulse latches the RE amount, REs and a
//           noise burst are packed into 128-bit words, done pulses once both
//           FIFOs hold the user's last word.
// Ports   : i_core_clk, i_rx_rstn (async, active-low)
//           i_user_start, i_cur_user_re_amounts      - open user
//           i_re_valid/o_re_ready, i_re_i, i_re_q    - RE stream
//           i_noise_valid/o_noise_ready, i_noise_data, i_noise_last - noise stream
//           o_iq_fifo_wr_en/o_iq_fifo_wdata/i_iq_fifo_full - IQ FIFO
//           o_nz_fifo_wr_en/o_nz_fifo_wdata/i_nz_fifo_full - noise FIFO
//           o_user_done, o_busy, o_protocol_err       - status
import llr_pkg::*;

module llr_iq_noise_packer #(
    parameter int DATA_W      = LLR_DATA_W,
    parameter int RE_PER_WORD = LLR_RE_PER_WORD,
    parameter int NZ_PER_WORD = LLR_NZ_PER_WORD,
    parameter int CNT_W       = LLR_CNT_W
) (
    input  logic                            i_core_clk,
    input  logic                            i_rx_rstn,
    input  logic                            i_user_start,
    input  logic [CNT_W-1:0]                i_cur_user_re_amounts,
    input  logic                            i_re_valid,
    output logic                            o_re_ready,
    input  logic [DATA_W-1:0]               i_re_i,
    input  logic [DATA_W-1:0]               i_re_q,
    input  logic                            i_noise_valid,
    output logic                            o_noise_ready,
    input  logic [DATA_W-1:0]               i_noise_data,
    input  logic                            i_noise_last,
    output logic                            o_iq_fifo_wr_en,
    output logic [RE_PER_WORD*2*DATA_W-1:0] o_iq_fifo_wdata,
    input  logic                            i_iq_fifo_full,
    output logic                            o_nz_fifo_wr_en,
    output logic [NZ_PER_WORD*DATA_W-1:0]   o_nz_fifo_wdata,
    input  logic                            i_nz_fifo_full,
    output logic                            o_user_done,
    output logic                            o_busy,
    output logic                            o_protocol_err
);

    llr_state_e       state;
    logic [CNT_W-1:0] amount;
    logic [CNT_W-1:0] re_cnt;
    logic             noise_done;
    logic             iq_allow;
    logic             nz_allow;
    logic             re_last;
    logic             re_fire;
    logic             nz_fire;
    logic             iq_pend;
    logic             nz_pend;

    assign iq_allow = (state == ST_PACK) && (re_cnt < amount);
    assign nz_allow = (state == ST_PACK) && !noise_done;
    assign re_last  = ((re_cnt + 1'b1) == amount);
    assign re_fire  = o_re_ready & i_re_valid;
    assign nz_fire  = o_noise_ready & i_noise_valid;

    llr_lane_packer #(
        .LANE_W (2 * DATA_W),
        .LANES  (RE_PER_WORD)
    ) u_iq_lane (
        .clk        (i_core_clk),
        .rstn       (i_rx_rstn),
        .allow      (iq_allow),
        .in_valid   (i_re_valid),
        .in_data    ({i_re_q, i_re_i}),
        .in_last    (re_last),
        .in_ready   (o_re_ready),
        .fifo_full  (i_iq_fifo_full),
        .wr_en      (o_iq_fifo_wr_en),
        .wdata      (o_iq_fifo_wdata),
        .pend_valid (iq_pend)
    );

    llr_lane_packer #(
        .LANE_W (DATA_W),
        .LANES  (NZ_PER_WORD)
    ) u_nz_lane (
        .clk        (i_core_clk),
        .rstn       (i_rx_rstn),
        .allow      (nz_allow),
        .in_valid   (i_noise_valid),
        .in_data    (i_noise_data),
        .in_last    (i_noise_last),
        .in_ready   (o_noise_ready),
        .fifo_full  (i_nz_fifo_full),
        .wr_en      (o_nz_fifo_wr_en),
        .wdata      (o_nz_fifo_wdata),
        .pend_valid (nz_pend)
    );

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state          <= ST_IDLE;
            amount         <= '0;
            re_cnt         <= '0;
            noise_done     <= 1'b0;
            o_user_done    <= 1'b0;
            o_busy         <= 1'b0;
            o_protocol_err <= 1'b0;
        end else begin
            o_user_done <= 1'b0;
            if ((i_user_start && state != ST_IDLE) ||
                (state == ST_IDLE && (i_re_valid || i_noise_valid))) begin
                o_protocol_err <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (i_user_start) begin
                        amount     <= i_cur_user_re_amounts;
                        re_cnt     <= '0;
                        noise_done <= 1'b0;
                        o_busy     <= 1'b1;
                        if (i_cur_user_re_amounts == '0) begin
                            state       <= ST_DONE;
                            o_user_done <= 1'b1;
                        end else begin
                            state <= ST_PACK;
                        end
                    end
                end
                ST_PACK: begin
                    if (re_fire) begin
                        re_cnt <= re_cnt + 1'b1;
                    end
                    if (nz_fire && i_noise_last) begin
                        noise_done <= 1'b1;
                    end
                    if (re_cnt == amount && noise_done) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!iq_pend && !nz_pend) begin
                        state       <= ST_DONE;
                        o_user_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llr_iq_noise_packer.sv
// tb/tb_llr_iq_noise_packer.sv - directed self-checking bench for llr_iq_noise_packer
module tb_llr_iq_noise_packer;

    logic         clk;
    logic         rstn;
    logic         user_start;
    logic [15:0]  re_amounts;
    logic         re_valid;
    logic         re_ready;
    logic [15:0]  re_i;
    logic [15:0]  re_q;
    logic         noise_valid;
    logic         noise_ready;
    logic [15:0]  noise_data;
    logic         noise_last;
    logic         iq_wr_en;
    logic [127:0] iq_wdata;
    logic         iq_full;
    logic         nz_wr_en;
    logic [127:0] nz_wdata;
    logic         nz_full;
    logic         user_done;
    logic         busy;
    logic         protocol_err;

    int errors = 0;
    int checks = 0;
    logic [127:0] iq_q[$];
    logic [127:0] nz_q[$];

    llr_iq_noise_packer dut (
        .i_core_clk            (clk),
        .i_rx_rstn             (rstn),
        .i_user_start          (user_start),
        .i_cur_user_re_amounts (re_amounts),
        .i_re_valid            (re_valid),
        .o_re_ready            (re_ready),
        .i_re_i                (re_i),
        .i_re_q                (re_q),
        .i_noise_valid         (noise_valid),
        .o_noise_ready         (noise_ready),
        .i_noise_data          (noise_data),
        .i_noise_last          (noise_last),
        .o_iq_fifo_wr_en       (iq_wr_en),
        .o_iq_fifo_wdata       (iq_wdata),
        .i_iq_fifo_full        (iq_full),
        .o_nz_fifo_wr_en       (nz_wr_en),
        .o_nz_fifo_wdata       (nz_wdata),
        .i_nz_fifo_full        (nz_full),
        .o_user_done           (user_done),
        .o_busy                (busy),
        .o_protocol_err        (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO write capture, mid-cycle; inputs only change 1ns after posedge.
    always @(negedge clk) begin
        if (rstn) begin
            if (iq_wr_en) iq_q.push_back(iq_wdata);
            if (nz_wr_en) nz_q.push_back(nz_wdata);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] amt);
        user_start = 1'b1;
        re_amounts = amt;
        tick();
        user_start = 1'b0;
    endtask

    task automatic send_re(input logic [15:0] i, input logic [15:0] q);
        int n = 0;
        re_valid = 1'b1;
        re_i = i;
        re_q = q;
        while (!re_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("re_ready_timeout", 1'b0, 1'b1);
        tick();
        re_valid = 1'b0;
    endtask

    task automatic send_nz(input logic [15:0] d, input logic last);
        int n = 0;
        noise_valid = 1'b1;
        noise_data = d;
        noise_last = last;
        while (!noise_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("noise_ready_timeout", 1'b0, 1'b1);
        tick();
        noise_valid = 1'b0;
        noise_last = 1'b0;
    endtask

    task automatic wait_done;
        int n = 0;
        while (!user_done && n < 200) begin
            tick();
            n++;
        end
        chk("done_seen", user_done, 1'b1);
        tick();
    endtask

    function automatic logic [127:0] pop_iq();
        if (iq_q.size() == 0) return '0;
        return iq_q.pop_front();
    endfunction

    function automatic logic [127:0] pop_nz();
        if (nz_q.size() == 0) return '0;
        return nz_q.pop_front();
    endfunction

    initial begin
        logic [127:0] w;
        int bad;
        rstn = 1'b0;
        user_start = 1'b0;
        re_amounts = '0;
        re_valid = 1'b0;
        re_i = '0;
        re_q = '0;
        noise_valid = 1'b0;
        noise_data = '0;
        noise_last = 1'b0;
        iq_full = 1'b0;
        nz_full = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", user_done, 1'b0);
        chk("rst_err", protocol_err, 1'b0);
        chk("rst_iq_wr", iq_wr_en, 1'b0);
        chk("rst_nz_wr", nz_wr_en, 1'b0);
        chk("rst_re_ready", re_ready, 1'b0);
        chk("rst_nz_ready", noise_ready, 1'b0);

        // User 1: amount=8, 8 noise samples
        pulse_start(16'd8);
        chk("u1_busy", busy, 1'b1);
        for (int k = 0; k < 4; k++) begin
            send_re(16'(k), 16'(16'h100 + k));
            if (k == 2) chk("u1_no_early_wr", iq_wr_en, 1'b0);
        end
        chk("u1_latency_wr", iq_wr_en, 1'b1);
        for (int k = 4; k < 8; k++) send_re(16'(k), 16'(16'h100 + k));
        chk("u1_re_ready_sat", re_ready, 1'b0);
        for (int k = 0; k < 8; k++) send_nz(16'(16'h200 + k), k == 7);
        wait_done();
        chk("u1_iq_cnt", 128'(iq_q.size()), 128'd2);
        chk("u1_nz_cnt", 128'(nz_q.size()), 128'd1);
        w = pop_iq();
        chk("u1_w0_re0_i", w[15:0], 16'h0000);
        chk("u1_w0_re1_i", w[47:32], 16'h0001);
        chk("u1_w0", w, 128'h0103_0003_0102_0002_0101_0001_0100_0000);
        chk("u1_w1", pop_iq(), 128'h0107_0007_0106_0006_0105_0005_0104_0004);
        chk("u1_nz", pop_nz(), 128'h0207_0206_0205_0204_0203_0202_0201_0200);
        chk("u1_idle", busy, 1'b0);

        // User 2: amount=6, 3 noise samples, partial words zero-filled
        pulse_start(16'd6);
        for (int k = 0; k < 6; k++) send_re(16'(k), 16'(16'h100 + k));
        for (int k = 0; k < 3; k++) send_nz(16'(16'h300 + k), k == 2);
        wait_done();
        chk("u2_iq_cnt", 128'(iq_q.size()), 128'd2);
        chk("u2_nz_cnt", 128'(nz_q.size()), 128'd1);
        chk("u2_w0", pop_iq(), 128'h0103_0003_0102_0002_0101_0001_0100_0000);
        chk("u2_w1", pop_iq(), 128'h0000_0000_0000_0000_0105_0005_0104_0004);
        chk("u2_nz", pop_nz(), 128'h0000_0000_0000_0000_0000_0302_0301_0300);

        // User 3: IQ FIFO full for 20 cycles with a pending word
        iq_full = 1'b1;
        pulse_start(16'd8);
        for (int k = 0; k < 4; k++) send_re(16'(16'h40 + k), 16'(16'h80 + k));
        re_valid = 1'b1;
        re_i = 16'h0044;
        re_q = 16'h0084;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (iq_wr_en !== 1'b0 || re_ready !== 1'b0) bad++;
            tick();
        end
        chk("u3_stall_cycles", 128'(bad), 128'd0);
        chk("u3_no_write_while_full", 128'(iq_q.size()), 128'd0);
        iq_full = 1'b0;
        #1;
        chk("u3_release_wr", iq_wr_en, 1'b1);
        for (int k = 4; k < 8; k++) send_re(16'(16'h40 + k), 16'(16'h80 + k));
        send_nz(16'h0501, 1'b1);
        wait_done();
        chk("u3_iq_cnt", 128'(iq_q.size()), 128'd2);
        chk("u3_w0", pop_iq(), 128'h0083_0043_0082_0042_0081_0041_0080_0040);
        chk("u3_w1", pop_iq(), 128'h0087_0047_0086_0046_0085_0045_0084_0044);
        chk("u3_nz", pop_nz(), 128'h0000_0000_0000_0000_0000_0000_0000_0501);

        // User 4: amount=0
        pulse_start(16'd0);
        chk("u4_done", user_done, 1'b1);
        chk("u4_busy", busy, 1'b1);
        tick();
        chk("u4_done_pulse", user_done, 1'b0);
        chk("u4_busy_end", busy, 1'b0);
        tick();
        chk("u4_no_iq", 128'(iq_q.size()), 128'd0);
        chk("u4_no_nz", 128'(nz_q.size()), 128'd0);

        // User 5: reset after 5 REs, then a clean user
        pulse_start(16'd8);
        for (int k = 0; k < 5; k++) send_re(16'(16'h50 + k), 16'(16'h55));
        rstn = 1'b0;
        #1;
        chk("u5_rst_busy", busy, 1'b0);
        chk("u5_rst_iq_wr", iq_wr_en, 1'b0);
        chk("u5_rst_ready", re_ready, 1'b0);
        chk("u5_rst_done", user_done, 1'b0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        iq_q.delete();
        nz_q.delete();
        pulse_start(16'd4);
        for (int k = 0; k < 4; k++) send_re(16'(16'h60 + k), 16'(16'h70 + k));
        send_nz(16'h0601, 1'b1);
        wait_done();
        chk("u5_iq_cnt", 128'(iq_q.size()), 128'd1);
        chk("u5_w0", pop_iq(), 128'h0073_0063_0072_0062_0071_0061_0070_0060);
        chk("u5_nz", pop_nz(), 128'h0000_0000_0000_0000_0000_0000_0000_0601);
        chk("u5_err_clear", protocol_err, 1'b0);

        // User 6: start during PACK is ignored but flagged
        pulse_start(16'd4);
        for (int k = 0; k < 2; k++) send_re(16'(16'h80 + k), 16'(16'h90 + k));
        pulse_start(16'd9);
        chk("u6_err_set", protocol_err, 1'b1);
        for (int k = 2; k < 4; k++) send_re(16'(16'h80 + k), 16'(16'h90 + k));
        send_nz(16'h0701, 1'b1);
        wait_done();
        chk("u6_err_sticky", protocol_err, 1'b1);
        chk("u6_iq_cnt", 128'(iq_q.size()), 128'd1);
        chk("u6_w0", pop_iq(), 128'h0093_0083_0092_0082_0091_0081_0090_0080);
        chk("u6_nz", pop_nz(), 128'h0000_0000_0000_0000_0000_0000_0000_0701);
        chk("u6_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
